// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - async FIFO read-side pointer, empty/almost-empty/underflow status
// Optional FIFO_RD_LEVEL_EN adds the registered rd_level output.
module fifo_read_ctrl #(
    parameter int addrbits = 8,
    parameter int AE_LEVEL = 2
) (
    input  logic                clk_out,
    input  logic                rst,
    input  logic                sync_flush,
    input  logic                rd_en,
    input  logic [addrbits:0]   sync_wrptr,
    output logic [addrbits:0]   rdptr,
    output logic [addrbits-1:0] raddr,
    output logic                rd_valid,
    output logic                empty,
    output logic                almost_empty,
    output logic                underflow
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [addrbits:0]   rd_level
`endif
);

    localparam logic [addrbits:0] AE_THRESH = AE_LEVEL[addrbits:0];

    logic [addrbits:0] rbin;
    logic [addrbits:0] rbin_next;
    logic [addrbits:0] rgray_next;
    logic [addrbits:0] wbin;
    logic [addrbits:0] level_next;
    logic              accept;

    // Registered empty gates the read, so sync_wrptr never reaches accept combinationally.
    assign accept     = rd_en & ~empty;
    assign rbin_next  = rbin + {{addrbits{1'b0}}, accept};
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    assign level_next = wbin - rbin_next;
    assign raddr      = rbin[addrbits-1:0];

    always_comb begin
        wbin = '0;
        for (int i = 0; i <= addrbits; i++) begin
            wbin[i] = ^(sync_wrptr >> i);
        end
    end

    always_ff @(posedge clk_out) begin
        if (rst || sync_flush) begin
            rbin         <= '0;
            rdptr        <= '0;
            rd_valid     <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            underflow    <= 1'b0;
`ifdef FIFO_RD_LEVEL_EN
            rd_level     <= '0;
`endif
        end else begin
            rbin         <= rbin_next;
            rdptr        <= rgray_next;
            rd_valid     <= accept;
            empty        <= (rgray_next == sync_wrptr);
            almost_empty <= (level_next <= AE_THRESH);
            underflow    <= rd_en & empty;
`ifdef FIFO_RD_LEVEL_EN
            rd_level     <= level_next;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - scoreboard bench for fifo_read_ctrl against an integer word-count model
module tb_fifo_read_ctrl;

    localparam int A  = 2;
    localparam int AE = 2;
    localparam int D  = 1 << A;
    localparam int M  = 1 << (A + 1);

    typedef struct packed {
        logic         valid;
        logic [A:0]   ptr;
        logic [A-1:0] addr;
        logic         emp;
        logic         ae;
        logic         uf;
        logic [A:0]   lvl;
    } exp_t;

    logic         clk_out = 1'b0;
    logic         rst = 1'b1;
    logic         sync_flush = 1'b0;
    logic         rd_en = 1'b0;
    logic [A:0]   sync_wrptr = '0;
    logic [A:0]   rdptr;
    logic [A-1:0] raddr;
    logic         rd_valid, empty, almost_empty, underflow;
`ifdef FIFO_RD_LEVEL_EN
    logic [A:0]   rd_level;
`endif

    fifo_read_ctrl #(.addrbits(A), .AE_LEVEL(AE)) dut (
        .clk_out(clk_out),
        .rst(rst),
        .sync_flush(sync_flush),
        .rd_en(rd_en),
        .sync_wrptr(sync_wrptr),
        .rdptr(rdptr),
        .raddr(raddr),
        .rd_valid(rd_valid),
        .empty(empty),
        .almost_empty(almost_empty),
        .underflow(underflow)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rd_level(rd_level)
`endif
    );

    always #5 clk_out = ~clk_out;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: total words written (W) and read (m_r) as plain integers.
    int   W      = 0;
    int   m_r    = 0;
    logic m_empty = 1'b1;

    function automatic logic [A:0] gray(input int v);
        logic [A:0] b;
        b = v[A:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic re);
        exp_t e;
        int   rn, lvl;
        logic acc;
        @(negedge clk_out);
        rst        = r;
        sync_flush = f;
        rd_en      = re;
        sync_wrptr = gray(W % M);
        acc = re && !m_empty;
        if (r || f) begin
            m_r = 0;
            m_empty = 1'b1;
            e.valid = 1'b0; e.ptr = '0; e.addr = '0;
            e.emp = 1'b1; e.ae = 1'b1; e.uf = 1'b0; e.lvl = '0;
        end else begin
            rn  = m_r + (acc ? 1 : 0);
            lvl = W - rn;
            e.valid = acc;
            e.ptr   = gray(rn % M);
            e.addr  = (rn % D);
            e.emp   = (lvl == 0);
            e.ae    = (lvl <= AE);
            e.uf    = re && m_empty;
            e.lvl   = lvl[A:0];
            m_r     = rn;
            m_empty = (lvl == 0);
        end
        q.push_back(e);
    endtask

    logic [A:0] prev_ptr = '0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_out);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_valid", rd_valid, e.valid);
                chk("rdptr", rdptr, e.ptr);
                chk("raddr", raddr, e.addr);
                chk("empty", empty, e.emp);
                chk("almost_empty", almost_empty, e.ae);
                chk("underflow", underflow, e.uf);
`ifdef FIFO_RD_LEVEL_EN
                chk("rd_level", rd_level, e.lvl);
`endif
                if (rd_valid) chk("rdptr_one_bit_step", $countones(prev_ptr ^ rdptr), 1);
            end
            prev_ptr = rdptr;
        end
    end

    initial begin
        int room, add;
        // Reset with a nonzero synchronized write pointer (gray 5 = binary 6).
        W = 6;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        W = 0;
        step(1'b0, 1'b0, 1'b0);

        // Burst of three, then a rejected fourth read.
        W = 3;
        step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Almost-empty boundary: level 3, then one read to level 2.
        W = m_r + 3;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Flush together with a read at level 2.
        step(1'b0, 1'b1, 1'b1);
        W = 0;
        step(1'b0, 1'b0, 1'b0);

        // Full-depth fill and drain across the pointer wrap.
        for (int k = 0; k < 10; k++) begin
            W = m_r + D;
            step(1'b0, 1'b0, 1'b0);
            repeat (D) step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end

        for (int k = 0; k < 600; k++) begin
            room = m_r + D - W;
            add  = int'($urandom_range(0, (room < 2) ? room : 2));
            W   += add;
            if ($urandom_range(0, 99) == 0) begin
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
                W = 0;
            end else if ($urandom_range(0, 199) == 0) begin
                step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
                W = 0;
            end else begin
                step(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0));
            end
        end

        step(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk_out);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller of the asynchronous FIFO, running entirely in the read clock domain. It owns the read pointer: it accepts read requests, generates the binary RAM read address, and publishes the Gray-coded read pointer that the read-pointer synchronizer carries into the write domain. It consumes the write pointer after that pointer has been synchronized into this domain, and from it derives the empty, almost-empty and underflow status.

## Interface
Parameters:
- addrbits, default 8: RAM address width. Depth is 2^addrbits. Pointers are addrbits+1 bits wide.
- AE_LEVEL, default 2: almost-empty threshold, in words. Legal range is 0..2^addrbits.

Ports:
- clk_out, input, 1: read-domain clock. All logic is on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- sync_flush, input, 1: synchronous flush. Returns the block to its reset state.
- rd_en, input, 1: read request.
- sync_wrptr, input, addrbits+1: Gray-coded write pointer, already synchronized into clk_out.
- rdptr, output, addrbits+1: registered Gray-coded read pointer, sent to the read-pointer synchronizer.
- raddr, output, addrbits: binary RAM read address. Equals rbin[addrbits-1:0].
- rd_valid, output, 1: registered. Marks the RAM output word as valid.
- empty, output, 1: registered empty flag.
- almost_empty, output, 1: registered. High when the fill level is at or below AE_LEVEL.
- underflow, output, 1: registered one-cycle pulse on a rejected read.
- rd_level, output, addrbits+1: present only when FIFO_RD_LEVEL_EN is defined.

## Operation
- State:
  - rbin: binary read counter, addrbits+1 bits, wraps modulo 2^(addrbits+1).
  - rdptr: holds gray(rbin) at all times, where gray(x) = x ^ (x >> 1).
- accept = rd_en & ~empty. The registered empty flag is used here; there is no combinational path from sync_wrptr to accept.
- rbin_next = rbin + accept.
- rgray_next = gray(rbin_next).
- wbin = gray-to-binary of sync_wrptr (XOR-prefix from the MSB down).
- level_next = (wbin − rbin_next) mod 2^(addrbits+1). The result is in 0..2^addrbits.
- Register updates on every edge, in priority order rst > sync_flush > normal:
  - rbin ← rbin_next
  - rdptr ← rgray_next
  - rd_valid ← accept
  - empty ← (rgray_next == sync_wrptr)
  - almost_empty ← (level_next ≤ AE_LEVEL)
  - underflow ← rd_en & empty
- The RAM read is synchronous. The RAM samples raddr on the edge where accept=1 and presents the data while rd_valid=1.
- Reset and flush values:
  - rbin=0, rdptr=0, raddr=0
  - rd_valid=0, underflow=0
  - empty=1, almost_empty=1
  - rd_level=0 (when present)
- A flush drops any read accepted in the same cycle: no rd_valid follows it.
- A read while empty is ignored. The pointers hold and underflow pulses.

## Timing
- Read latency: rd_en=1 with empty=0 at edge N gives rd_valid=1 and the new rdptr during cycle N+1.
- Sustained throughput is one word per clock, with no bubbles while the FIFO is non-empty.
- Last-word read: empty rises in the cycle right after the accepting edge. There is no extra read window.
- Empty release: empty falls one edge after sync_wrptr changes. The synchronizer adds its own two edges on top of this, so the release is pessimistic, never optimistic.
- Simultaneous read and sync_wrptr change: empty and level are computed from the post-read pointer against the current sync_wrptr.
- Wrap-around: rdptr changes exactly one bit per accepted read, including the rbin 2^(addrbits+1)−1 → 0 step.
- rst or sync_flush asserted mid-burst: the next edge applies the reset values. Reads may resume one cycle after the control signal deasserts.

## Configuration
- FIFO_RD_LEVEL_EN:
  - Defined: adds the rd_level output, registered as level_next. The value is stale by up to the synchronizer delay and therefore never under-reports the read-side view of empty.
  - Undefined: the port and its register are absent. almost_empty still uses an internal level_next.

## Test plan
- Reset: hold rst high for 2 cycles with sync_wrptr=5 → rdptr=0, raddr=0, empty=1, almost_empty=1, rd_valid=0, underflow=0.
- Burst read (addrbits=8): drive sync_wrptr=gray(3)=2, wait 1 cycle, then hold rd_en high for 3 cycles:
  - raddr=0,1,2 on the accepting edges
  - rd_valid high for 3 cycles, starting one cycle later
  - rdptr=1,3,2
  - empty=1 after the third read; a 4th rd_en is rejected with a single underflow pulse
- Underflow: pulse rd_en while empty → underflow=1 for exactly 1 cycle; rdptr and raddr unchanged; rd_valid=0.
- Wrap (addrbits=2): run 10 write/read pairs → rbin passes 7→0 with rdptr going 4→0; raddr sequence is 0,1,2,3,0,1,…; every rdptr step is a single-bit change; no false empty or underflow.
- Flush: with level 2, assert sync_flush together with rd_en → next cycle rdptr=0, empty=1, rd_valid=0.
- Almost-empty (AE_LEVEL=2): level 3 gives almost_empty=0; one read to level 2 gives 1; with FIFO_RD_LEVEL_EN defined, rd_level reads 3 then 2.
